// File: rtl/k12a_pkg.sv
// K12A shared definitions.
// Run-controller FSM state encoding.
package k12a_pkg;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP0 = 2'd2,
        STEP1 = 2'd3
    } run_state_t;

endpackage

// File: rtl/k12a_debounce.sv
// K12A panel input conditioner.
// Two-flop synchroniser followed by a stable-count debouncer.
module k12a_debounce
    import k12a_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic sys_clock,
    input  logic reset_n,
    input  logic in,
    output logic out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter reaching DEBOUNCE_CYCLES is detected one step early
    // so the flip and the clear happen on the same edge.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser chain, debounced level and stability counter.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out = deb_q;

endmodule

// File: rtl/k12a_run_ctl.sv
// K12A front-panel run/halt/single-step controller.
// Gates the CPU clock in whole CPU cycles (even sys_clock runs).
module k12a_run_ctl
    import k12a_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic sys_clock,
    input  logic reset_n,
    input  logic run_sw,
    input  logic step_btn,
    input  logic halt_req,
    output logic clock_enable,
    output logic halted
);

    logic       run_deb;
    logic       step_deb;
    logic       run_prev_q;
    logic       step_prev_q;
    logic       halt_latch_q;
    logic       halt_latch_d;
    logic       phase_q;
    logic       ce_q;
    logic       halted_q;
    logic       step_pulse;
    logic       run_fall;
    logic       run_ok;
    run_state_t state_q;
    run_state_t state_d;

    k12a_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_deb (
        .sys_clock(sys_clock),
        .reset_n  (reset_n),
        .in       (run_sw),
        .out      (run_deb)
    );

    k12a_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_deb (
        .sys_clock(sys_clock),
        .reset_n  (reset_n),
        .in       (step_btn),
        .out      (step_deb)
    );

    assign step_pulse = step_deb & ~step_prev_q;
    assign run_fall   = ~run_deb & run_prev_q;
    assign run_ok     = run_deb & ~halt_latch_q & ~halt_req;

    // Halt latch: a CPU request wins over a run-switch release.
    always_comb begin
        halt_latch_d = halt_latch_q;
        if (halt_req) begin
            halt_latch_d = 1'b1;
        end else if (run_fall) begin
            halt_latch_d = 1'b0;
        end
    end

    // Next state; RUN only leaves after the second half of a CPU cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALT: begin
                if (run_ok) begin
                    state_d = RUN;
                end else if (step_pulse) begin
                    state_d = STEP0;
                end
            end
            RUN: begin
                if (!run_ok && phase_q) begin
                    state_d = HALT;
                end
            end
            STEP0:   state_d = STEP1;
            STEP1:   state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // State, edge history, latch, phase and registered outputs.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= HALT;
            run_prev_q   <= 1'b0;
            step_prev_q  <= 1'b0;
            halt_latch_q <= 1'b0;
            phase_q      <= 1'b0;
            ce_q         <= 1'b0;
            halted_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            run_prev_q   <= run_deb;
            step_prev_q  <= step_deb;
            halt_latch_q <= halt_latch_d;
            phase_q      <= phase_q ^ ce_q;
            ce_q         <= (state_d != HALT);
            halted_q     <= (state_d == HALT);
        end
    end

    assign clock_enable = ce_q;
    assign halted       = halted_q;

endmodule

// File: doc/k12a_run_ctl.md
# k12a_run_ctl

Front-panel run/halt/single-step controller for the K12A CPU clock. Sits directly upstream of the clock controller: it synchronises and debounces the panel run switch and step button, tracks CPU halt requests, and drives the `clock_enable` that gates CPU clock toggling. Enable pulses are always whole CPU cycles, i.e. even-length runs of `sys_clock` cycles, so the CPU clock never stops mid-cycle.

## Interface
- `DEBOUNCE_CYCLES`, default 65536: consecutive stable `sys_clock` samples required before a debounced input changes. Minimum 1.
- `sys_clock`, input, 1: system clock; the only clock in the block.
- `reset_n`, input, 1: reset. Asynchronous, active-low.
- `run_sw`, input, 1: panel run switch, asynchronous and bouncy. 1 = run.
- `step_btn`, input, 1: panel step button, asynchronous and bouncy. 1 = pressed.
- `halt_req`, input, 1: CPU halt request, synchronous to `sys_clock`, level.
- `clock_enable`, output, 1: registered; 1 = clock controller may toggle `cpu_clock` this cycle.
- `halted`, output, 1: registered; 1 while the FSM is in HALT.

## Operation
- **Synchronisers:** `run_sw` and `step_btn` each pass through a 2-flop synchroniser. Reset value 0.
- **Debounce (per input):**
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synced input equals the debounced value.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES, the debounced value takes the synced value and the counter clears.
  - Debounced values reset to 0.
- **Step pulse:** one-cycle pulse on a debounced `step_btn` 0→1 edge. It needs a previous-value register, which resets to 0.
- **Halt latch:**
  - Set on any cycle with `halt_req`=1.
  - Cleared on a debounced `run_sw` 1→0 edge.
  - Set takes priority over clear. Reset value 0.
- **Run permission:** `run_ok` = debounced run & ~halt_latch & ~`halt_req`.
- **Phase bit:** toggles every cycle `clock_enable`=1. Reset value 0. It equals 0 at the start of each CPU cycle.
- **FSM states:** HALT (reset state), RUN, STEP0, STEP1.
  - HALT:
    - `run_ok` → RUN.
    - Otherwise, if the step pulse fires → STEP0.
    - Otherwise stay.
  - RUN: if `run_ok`=0 and phase=1 → HALT. Otherwise stay. Exit happens only after the second half of a CPU cycle.
  - STEP0: → STEP1 unconditionally.
  - STEP1: → HALT unconditionally.
- **Outputs (registered from the next state):**
  - `clock_enable` = 1 in RUN, STEP0 and STEP1.
  - `halted` = 1 in HALT.
  - Reset values: `clock_enable`=0, `halted`=1.
- **Step pulse outside HALT:** ignored in RUN, STEP0 and STEP1. It is not queued.
- **`halt_req` in HALT:** blocks RUN only; stepping remains possible (this is how the halted CPU is single-stepped).

## Timing
- `run_sw` change → debounced change: 2 + DEBOUNCE_CYCLES cycles after the input settles.
- Debounced run 0→1 in HALT (halt latch clear) → `clock_enable`=1 on the next cycle. `halted` falls on the same edge.
- Run dropped or `halt_req` asserted in RUN:
  - Phase 0 at detection: `clock_enable` stays 1 one more cycle, then goes 0.
  - Phase 1 at detection: `clock_enable` goes 0 at the next edge.
  - In both cases the total enabled-cycle count is even.
- Step pulse in HALT → `clock_enable`=1 for exactly 2 cycles, starting the cycle after the pulse. `halted` returns to 1 on the same edge `clock_enable` drops.
- **Simultaneous events in HALT:**
  - `run_ok` and step pulse together: RUN wins and the step is discarded.
  - Run falling edge and `halt_req` together: latch set.
- **Reset mid-operation:** all state returns to reset values asynchronously. `clock_enable` drops immediately, and the phase bit clears.

## Structure
- Shared package `k12a_pkg` holds the `run_state_t` enum (HALT, RUN, STEP0, STEP1).
- One sub-module, `k12a_debounce`:
  - Contains the synchroniser and debounce counter.
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports `sys_clock`, `reset_n`, `in`, `out`.
  - Instantiated twice.
- Edge detection, halt latch, phase bit and FSM live in `k12a_run_ctl`.

## Test plan
Directed tests use DEBOUNCE_CYCLES=4.
- **Reset:** hold `reset_n`=0 with all inputs 1 → `clock_enable`=0, `halted`=1. Release: `clock_enable` rises 7 cycles later (2 sync + 4 debounce + 1).
- **Bounce rejection:** toggle `run_sw` 1/0 every 3 cycles for 30 cycles, then hold 0 → `clock_enable` stays 0 throughout.
- **Single step:** clean `step_btn` press for 10 cycles in HALT → exactly 2 `clock_enable`=1 cycles, then `halted`=1. Holding the button produces no further pulses.
- **Halt mid-run:** in RUN, assert `halt_req` one cycle on phase=0 → exactly 1 more enabled cycle. Then `halted`=1 and RUN is not re-entered until `run_sw` is cycled 1→0→1 (each level held ≥7 cycles).
- **Step while halted by CPU:** `halt_req` held high in HALT, step press → 2 enabled cycles despite `halt_req`.
- **Step ignored in RUN, and async reset:** step press during RUN → enabled-cycle count unaffected. Pulse `reset_n` low mid-RUN → `clock_enable` goes 0 with no clock edge, and the phase bit reads 0 after reset.
